// File: rtl/score_disp_mux.sv
// Four-digit multiplexed 7-segment driver for two 2-digit BCD scores.
// It shows a per-frame snapshot and supports leading-zero blanking, win flash and a dash for invalid digits.
module score_disp_mux #(
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned FLASH_FRAMES = 64
) (
    input  logic       CLK,
    input  logic       CLRN,
    input  logic [7:0] SCORE_L,
    input  logic [7:0] SCORE_R,
    input  logic       BLANK_LZ,
    input  logic       FLASH,
    output logic [3:0] AN,
    output logic [6:0] SEG,
    output logic       DP
);

    localparam int unsigned PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned FW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);
    localparam logic [FW-1:0] FRAME_MAX = FW'(FLASH_FRAMES - 1);

    localparam logic [1:0] D0 = 2'd0;
    localparam logic [1:0] D1 = 2'd1;
    localparam logic [1:0] D2 = 2'd2;
    localparam logic [1:0] D3 = 2'd3;

    localparam logic [3:0] AN_OFF  = 4'hF;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    logic [PW-1:0] presc;
    logic [1:0]    state;
    logic [1:0]    state_nx;
    logic [7:0]    snap_l;
    logic [7:0]    snap_r;
    logic [7:0]    snap_l_nx;
    logic [7:0]    snap_r_nx;
    logic [FW-1:0] frame_cnt;
    logic [FW-1:0] frame_nx;
    logic          phase_on;
    logic          phase_nx;
    logic [3:0]    an_nx;
    logic [6:0]    seg_nx;
    logic          dp_nx;
    logic          tick_c;
    logic [3:0]    nib;
    logic          upper;
    logic          blank;

    // Active-low segment pattern; nibbles A-F show a dash.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    assign tick_c = (presc == PRESC_MAX);

    // State, snapshot, flash and output registers.
    always_ff @(posedge CLK or negedge CLRN) begin
        if (!CLRN) begin
            presc     <= '0;
            state     <= D3;
            snap_l    <= 8'h00;
            snap_r    <= 8'h00;
            frame_cnt <= '0;
            phase_on  <= 1'b1;
            AN        <= AN_OFF;
            SEG       <= SEG_OFF;
            DP        <= 1'b1;
        end else begin
            presc     <= tick_c ? '0 : presc + PW'(1);
            state     <= state_nx;
            snap_l    <= snap_l_nx;
            snap_r    <= snap_r_nx;
            frame_cnt <= frame_nx;
            phase_on  <= phase_nx;
            AN        <= an_nx;
            SEG       <= seg_nx;
            DP        <= dp_nx;
        end
    end

    // Next-state, snapshot capture, flash phase and digit output decode.
    always_comb begin
        state_nx  = state;
        snap_l_nx = snap_l;
        snap_r_nx = snap_r;
        frame_nx  = frame_cnt;
        phase_nx  = phase_on;
        an_nx     = AN;
        seg_nx    = SEG;
        dp_nx     = DP;
        nib       = 4'h0;
        upper     = 1'b0;
        blank     = 1'b0;

        if (tick_c) begin
            case (state)
                D0:      state_nx = D1;
                D1:      state_nx = D2;
                D2:      state_nx = D3;
                default: state_nx = D0;
            endcase
            if (state == D3) begin
                snap_l_nx = SCORE_L;
                snap_r_nx = SCORE_R;
                if (frame_cnt == FRAME_MAX) begin
                    frame_nx = '0;
                    phase_nx = ~phase_on;
                end else begin
                    frame_nx = frame_cnt + FW'(1);
                end
            end
        end

        // With flash off the phase restarts lit, so a new flash begins with a full ON half-period.
        if (!FLASH) begin
            frame_nx = '0;
            phase_nx = 1'b1;
        end

        if (tick_c) begin
            case (state_nx)
                D0: begin
                    nib   = snap_r_nx[3:0];
                    an_nx = 4'b1110;
                end
                D1: begin
                    nib   = snap_r_nx[7:4];
                    upper = 1'b1;
                    an_nx = 4'b1101;
                end
                D2: begin
                    nib   = snap_l_nx[3:0];
                    an_nx = 4'b1011;
                end
                default: begin
                    nib   = snap_l_nx[7:4];
                    upper = 1'b1;
                    an_nx = 4'b0111;
                end
            endcase
            blank  = (BLANK_LZ && upper && (nib == 4'h0)) || (FLASH && !phase_nx);
            seg_nx = seg_decode(nib);
            dp_nx  = (state_nx != D2);
            if (blank) begin
                an_nx  = AN_OFF;
                seg_nx = SEG_OFF;
                dp_nx  = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_score_disp_mux.sv
// Directed bench for score_disp_mux with REFRESH_DIV=4 and FLASH_FRAMES=2.
// Each step is checked on the falling edge, counting cycles from reset release.
module tb_score_disp_mux;

    logic       CLK;
    logic       CLRN;
    logic [7:0] SCORE_L;
    logic [7:0] SCORE_R;
    logic       BLANK_LZ;
    logic       FLASH;
    logic [3:0] AN;
    logic [6:0] SEG;
    logic       DP;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    score_disp_mux #(
        .REFRESH_DIV (4),
        .FLASH_FRAMES(2)
    ) dut (
        .CLK     (CLK),
        .CLRN    (CLRN),
        .SCORE_L (SCORE_L),
        .SCORE_R (SCORE_R),
        .BLANK_LZ(BLANK_LZ),
        .FLASH   (FLASH),
        .AN      (AN),
        .SEG     (SEG),
        .DP      (DP)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [3:0] an_e, input logic [6:0] seg_e,
                       input logic dp_e);
        checks++;
        assert (AN === an_e) else begin
            failures++;
            $error("FAIL %s AN observed=%h expected=%h", tag, AN, an_e);
        end
        checks++;
        assert (SEG === seg_e) else begin
            failures++;
            $error("FAIL %s SEG observed=%h expected=%h", tag, SEG, seg_e);
        end
        checks++;
        assert (DP === dp_e) else begin
            failures++;
            $error("FAIL %s DP observed=%b expected=%b", tag, DP, dp_e);
        end
    endtask

    // Advance to the falling edge numbered n after reset release.
    task automatic goto(input int n);
        while (cyc < n) begin
            @(negedge CLK);
            cyc++;
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        CLRN     = 1'b0;
        SCORE_L  = 8'h12;
        SCORE_R  = 8'h07;
        BLANK_LZ = 1'b0;
        FLASH    = 1'b0;
        @(negedge CLK);
        chk("reset", 4'hF, 7'h7F, 1'b1);
        @(negedge CLK);
        CLRN = 1'b1;
        cyc  = 0;

        // Scenario 1: basic scan order and decode
        goto(1);  chk("t1_blank1",    4'hF, 7'h7F, 1'b1);
        goto(3);  chk("t1_blank3",    4'hF, 7'h7F, 1'b1);
        goto(4);  chk("t1_d0",        4'hE, 7'h78, 1'b1);
        goto(7);  chk("t1_d0_hold",   4'hE, 7'h78, 1'b1);
        goto(8);  chk("t1_d1",        4'hD, 7'h40, 1'b1);
        goto(12); chk("t1_d2",        4'hB, 7'h24, 1'b0);
        goto(16); chk("t1_d3",        4'h7, 7'h79, 1'b1);
        goto(20); chk("t1_d0_repeat", 4'hE, 7'h78, 1'b1);

        // Scenario 2: leading-zero blanking
        BLANK_LZ = 1'b1;
        goto(24); chk("t2_d1_blank",  4'hF, 7'h7F, 1'b1);
        goto(28); chk("t2_d2",        4'hB, 7'h24, 1'b0);
        goto(32); chk("t2_d3_lit",    4'h7, 7'h79, 1'b1);
        goto(36); chk("t2_d0",        4'hE, 7'h78, 1'b1);

        // Scenario 3: mid-frame score change stays hidden until next frame
        goto(37); SCORE_R = 8'h08;
        goto(39); chk("t3_d0_hold",   4'hE, 7'h78, 1'b1);
        goto(52); chk("t3_d0_new",    4'hE, 7'h00, 1'b1);

        // Scenario 4: invalid lower digit shows a dash
        goto(53); SCORE_L = 8'h1A;
        goto(60); chk("t4_d2_old",    4'hB, 7'h24, 1'b0);
        goto(76); chk("t4_d2_dash",   4'hB, 7'h3F, 1'b0);
        goto(80); chk("t4_d3",        4'h7, 7'h79, 1'b1);

        // Scenario 5: flash toggles every two frames
        FLASH = 1'b1;
        goto(84);  chk("t5_on_d0",    4'hE, 7'h00, 1'b1);
        goto(92);  chk("t5_on_d2",    4'hB, 7'h3F, 1'b0);
        goto(100); chk("t5_off_d0",   4'hF, 7'h7F, 1'b1);
        goto(108); chk("t5_off_d2",   4'hF, 7'h7F, 1'b1);
        goto(116); chk("t5_off2_d0",  4'hF, 7'h7F, 1'b1);
        goto(132); chk("t5_on2_d0",   4'hE, 7'h00, 1'b1);
        goto(140); chk("t5_on2_d2",   4'hB, 7'h3F, 1'b0);
        goto(164); chk("t5_off3_d0",  4'hF, 7'h7F, 1'b1);
        goto(170); FLASH = 1'b0;
        goto(171); chk("t5_drop_hold", 4'hF, 7'h7F, 1'b1);
        goto(172); chk("t5_relight",   4'hB, 7'h3F, 1'b0);

        // Scenario 6: asynchronous reset mid-D2, then a fresh snapshot
        goto(174);
        SCORE_R = 8'h35;
        CLRN    = 1'b0;
        #1;
        chk("t6_async_blank", 4'hF, 7'h7F, 1'b1);
        repeat (2) @(negedge CLK);
        chk("t6_in_reset",    4'hF, 7'h7F, 1'b1);
        CLRN = 1'b1;
        cyc  = 0;
        goto(3);  chk("t6_blank3",  4'hF, 7'h7F, 1'b1);
        goto(4);  chk("t6_d0",      4'hE, 7'h12, 1'b1);
        goto(8);  chk("t6_d1",      4'hD, 7'h30, 1'b1);
        goto(12); chk("t6_d2",      4'hB, 7'h3F, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
